// File: rtl/cnn_bridge_pkg.sv
// Shared types and helpers for the conv-to-dnn bridge.
// Default widths match the standard conv/dnn configuration.
package cnn_bridge_pkg;

    localparam int BIT_SIZE  = 32;
    localparam int NUM_LANES = 2;
    localparam int NUM_OF_K  = 4;

    typedef logic [BIT_SIZE-1:0] lane_word_t;

    typedef struct packed {
        logic [NUM_OF_K-1:0]              valid;
        lane_word_t [NUM_LANES-1:0]       data;
        logic                             set_done;
    } pipe_stage_t;

    // Reverses the low n bits of v; bits at n and above come out as 0.
    function automatic logic [31:0] reverse_bits(input logic [31:0] v, input int unsigned n);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) r[i] = v[n-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bridge_pipe_stage.sv
// One register stage of the bridge pipe: loads d when en is high,
// clears synchronously on res.
module bridge_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         res,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (res)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/conv_dnn_bridge.sv
// Stallable re-timing pipe between conv and dnn stages, with image-set
// counting, periodic dnn flush pulse and sticky overflow flag.
module conv_dnn_bridge
    import cnn_bridge_pkg::*;
#(
    parameter int BitSize      = BIT_SIZE,
    parameter int NumLanes     = NUM_LANES,
    parameter int NumOfK       = NUM_OF_K,
    parameter int ImagesPerSet = 4,
    parameter int PipeDepth    = 1,
    parameter bit ReverseValid = 1'b1
) (
    input  logic                               clk,
    input  logic                               res,
    input  logic [NumOfK-1:0]                  in_valid,
    input  logic [NumLanes*BitSize-1:0]        in_data,
    input  logic                               in_set_done,
    input  logic                               in_conv_ready,
    input  logic                               in_dnn_ready,
    output logic                               out_ready,
    output logic [NumOfK-1:0]                  out_valid,
    output logic [NumLanes*BitSize-1:0]        out_data,
    output logic                               out_fl_res,
    output logic [$clog2(ImagesPerSet+1)-1:0]  out_set_cnt,
    output logic                               out_overflow
);

    localparam int DW = NumLanes * BitSize;
    localparam int SW = NumOfK + DW + 1;
    localparam int CW = $clog2(ImagesPerSet + 1);

    logic [SW-1:0]       stage_q [PipeDepth];
    logic [SW-1:0]       last;
    logic [NumOfK-1:0]   last_valid;
    logic                last_sd;
    logic                advance;
    logic                exit_sd;
    logic                wrap;
    logic [CW-1:0]       set_cnt;

    assign advance   = in_dnn_ready;
    assign out_ready = in_conv_ready & in_dnn_ready;

    for (genvar g = 0; g < PipeDepth; g++) begin : g_stage
        logic [SW-1:0] d;
        if (g == 0) begin : g_head
            assign d = {in_valid, in_data, in_set_done};
        end else begin : g_body
            assign d = stage_q[g-1];
        end
        bridge_pipe_stage #(.W(SW)) u_stage (
            .clk (clk),
            .res (res),
            .en  (advance),
            .d   (d),
            .q   (stage_q[g])
        );
    end

    assign last       = stage_q[PipeDepth-1];
    assign last_valid = last[SW-1 -: NumOfK];
    assign out_data   = last[DW:1];
    assign last_sd    = last[0];

    if (ReverseValid) begin : g_rev
        assign out_valid = NumOfK'(reverse_bits(32'(last_valid), unsigned'(NumOfK)));
    end else begin : g_fwd
        assign out_valid = last_valid;
    end

    // A set is counted only as it leaves the pipe, so a stall holds the count.
    assign exit_sd = advance & last_sd;
    assign wrap    = (set_cnt == CW'(ImagesPerSet - 1));

    always_ff @(posedge clk) begin
        if (res) begin
            set_cnt      <= '0;
            out_fl_res   <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            out_fl_res <= exit_sd & wrap;
            if (exit_sd) set_cnt <= wrap ? '0 : set_cnt + CW'(1);
            if (!advance && ((|in_valid) || in_set_done)) out_overflow <= 1'b1;
        end
    end

    assign out_set_cnt = set_cnt;

endmodule

// File: tb/tb_conv_dnn_bridge.sv
// Self-checking bench: two bridge configurations share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_conv_dnn_bridge;

    logic        clk = 1'b0;
    logic        res;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic        in_set_done;
    logic        in_conv_ready;
    logic        in_dnn_ready;

    logic        ready_a, fl_a, ovf_a;
    logic [3:0]  valid_a;
    logic [63:0] data_a;
    logic [2:0]  cnt_a;

    logic        ready_b, fl_b, ovf_b;
    logic [3:0]  valid_b;
    logic [63:0] data_b;
    logic [1:0]  cnt_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv_dnn_bridge #(.ImagesPerSet(4), .PipeDepth(2), .ReverseValid(1'b1)) dut_a (
        .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
        .in_set_done(in_set_done), .in_conv_ready(in_conv_ready), .in_dnn_ready(in_dnn_ready),
        .out_ready(ready_a), .out_valid(valid_a), .out_data(data_a),
        .out_fl_res(fl_a), .out_set_cnt(cnt_a), .out_overflow(ovf_a)
    );

    conv_dnn_bridge #(.ImagesPerSet(2), .PipeDepth(1), .ReverseValid(1'b1)) dut_b (
        .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
        .in_set_done(in_set_done), .in_conv_ready(in_conv_ready), .in_dnn_ready(in_dnn_ready),
        .out_ready(ready_b), .out_valid(valid_b), .out_data(data_b),
        .out_fl_res(fl_b), .out_set_cnt(cnt_b), .out_overflow(ovf_b)
    );

    typedef struct packed {
        logic [3:0]  v;
        logic [63:0] d;
        logic        sd;
    } beat_t;

    // Reference model: each in-flight beat list holds exactly depth entries,
    // oldest first; the oldest is what the dnn side sees.
    beat_t m_q   [2][$];
    int    m_cnt [2];
    bit    m_fl  [2];
    bit    m_ovf [2];
    int    depth [2] = '{2, 1};
    int    ips   [2] = '{4, 2};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k].delete();
            for (int i = 0; i < depth[k]; i++) m_q[k].push_back('0);
            m_cnt[k] = 0;
            m_fl[k]  = 1'b0;
            m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        beat_t b;
        if (res) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            m_fl[k] = 1'b0;
            if (in_dnn_ready) begin
                b = m_q[k].pop_front();
                m_q[k].push_back('{in_valid, in_data, in_set_done});
                if (b.sd) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == ips[k]) begin
                        m_cnt[k] = 0;
                        m_fl[k]  = 1'b1;
                    end
                end
            end else if (in_valid != 4'd0 || in_set_done) begin
                m_ovf[k] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {<<{v}};
    endfunction

    task automatic check_all();
        logic exp_ready;
        exp_ready = in_conv_ready & in_dnn_ready;
        chk("ready_a", 64'(ready_a), 64'(exp_ready));
        chk("ready_b", 64'(ready_b), 64'(exp_ready));
        chk("valid_a", 64'(valid_a), 64'(rev4(m_q[0][0].v)));
        chk("data_a",  data_a,       m_q[0][0].d);
        chk("fl_a",    64'(fl_a),    64'(m_fl[0]));
        chk("cnt_a",   64'(cnt_a),   64'(m_cnt[0]));
        chk("ovf_a",   64'(ovf_a),   64'(m_ovf[0]));
        chk("valid_b", 64'(valid_b), 64'(rev4(m_q[1][0].v)));
        chk("data_b",  data_b,       m_q[1][0].d);
        chk("fl_b",    64'(fl_b),    64'(m_fl[1]));
        chk("cnt_b",   64'(cnt_b),   64'(m_cnt[1]));
        chk("ovf_b",   64'(ovf_b),   64'(m_ovf[1]));
    endtask

    // Drive inputs, take one edge, advance the model, compare 1 time unit later.
    task automatic step(input logic r, input logic [3:0] v, input logic [63:0] d,
                        input logic sd, input logic rdy);
        @(negedge clk);
        res = r; in_valid = v; in_data = d; in_set_done = sd;
        in_conv_ready = 1'b1; in_dnn_ready = rdy;
        #1;
        chk("ready_comb", 64'({ready_a, ready_b}), 64'({2{rdy}}));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
    endtask

    task automatic set_pulse();
        step(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
    endtask

    initial begin
        res = 1'b1; in_valid = '0; in_data = '0; in_set_done = 1'b0;
        in_conv_ready = 1'b1; in_dnn_ready = 1'b1;
        model_reset();

        step(1'b1, 4'd0, 64'd0, 1'b0, 1'b1);
        step(1'b1, 4'd0, 64'd0, 1'b0, 1'b1);
        chk("reset_valid_a", 64'(valid_a), 64'd0);
        chk("reset_cnt_a", 64'(cnt_a), 64'd0);

        // pass-through, two-stage latency, reversed valid
        step(1'b0, 4'b0001, {32'hA, 32'hB}, 1'b0, 1'b1);
        step(1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        chk("pass_valid_a", 64'(valid_a), 64'(4'b1000));
        chk("pass_data_a", data_a, {32'hA, 32'hB});
        idle(2);

        // four isolated sets -> one flush on the big instance
        for (int i = 0; i < 4; i++) begin
            set_pulse();
            idle(2);
        end
        chk("flush_cnt_a", 64'(cnt_a), 64'd0);

        // stall with no input, then release
        step(1'b0, 4'b0100, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        idle(3);

        // overflow: input offered during a stall is dropped
        step(1'b0, 4'b0010, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
        chk("ovf_set_a", 64'(ovf_a), 64'd1);
        idle(3);
        chk("ovf_held_a", 64'(ovf_a), 64'd1);

        // reset mid-set, then a full set of four
        set_pulse(); idle(1); set_pulse(); idle(1);
        step(1'b1, 4'd0, 64'd0, 1'b0, 1'b1);
        chk("midreset_ovf_a", 64'(ovf_a), 64'd0);
        for (int i = 0; i < 4; i++) begin
            set_pulse();
            idle(2);
        end

        // back-to-back sets
        set_pulse(); set_pulse(); idle(3);
        chk("b2b_cnt_b", 64'(cnt_b), 64'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom),
                 {$urandom, $urandom},
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 80));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
